// File: rtl/ctrl_event_sched.sv
// ctrl_event_sched: time-triggered (step time, value) event sequencer; CTRL_EVENT_SCHED_LOOP_EN makes the sequence repeat
module ctrl_event_sched #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int CNT_W  = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              sta,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [CNT_W-1:0]  cfg_time,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic [AW:0]       cfg_num,
    input  logic              arm,
    input  logic              step_en,
    input  logic [CNT_W-1:0]  counter,
    output logic [DATA_W-1:0] y,
    output logic              y_upd,
    output logic [AW:0]       evt_idx,
    output logic              busy,
    output logic              done
`ifdef CTRL_EVENT_SCHED_LOOP_EN
    ,
    output logic              wrap_pulse
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tbl_time_q [DEPTH];
    logic [DATA_W-1:0]   tbl_val_q  [DEPTH];
    logic [DATA_W-1:0]   y_q, y_d;
    logic                upd_q, upd_d;
    logic [AW:0]         idx_q, idx_d;
    logic [AW:0]         num_q, num_d;
    logic                wrap_q, wrap_d;
    logic                match, last;
    always_ff @(posedge clk)
        if (!sta && cfg_we && state_q != RUN) begin
            tbl_time_q[cfg_addr] <= cfg_time;
            tbl_val_q[cfg_addr]  <= cfg_value;
        end
    // the event fires on the step that lands one before its scheduled time
    assign match = state_q == RUN && step_en &&
                   counter == tbl_time_q[idx_q[AW-1:0]] - CNT_W'(1);
    assign last  = idx_q == num_q - (AW+1)'(1);
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        upd_d   = 1'b0;
        idx_d   = idx_q;
        num_d   = num_q;
        wrap_d  = 1'b0;
        if (arm) begin
            num_d   = cfg_num > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : cfg_num;
            idx_d   = '0;
            y_d     = '0;
            state_d = cfg_num == '0 ? DONE : RUN;
        end else if (match) begin
            y_d   = tbl_val_q[idx_q[AW-1:0]];
            upd_d = 1'b1;
`ifdef CTRL_EVENT_SCHED_LOOP_EN
            idx_d  = last ? '0 : idx_q + (AW+1)'(1);
            wrap_d = last;
`else
            idx_d   = idx_q + (AW+1)'(1);
            state_d = last ? DONE : RUN;
`endif
        end
    end
    always_ff @(posedge clk)
        if (sta) begin
            state_q <= IDLE;
            y_q     <= '0;
            upd_q   <= 1'b0;
            idx_q   <= '0;
            num_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            upd_q   <= upd_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            wrap_q  <= wrap_d;
        end
    assign y       = y_q;
    assign y_upd   = upd_q;
    assign evt_idx = idx_q;
    assign busy    = state_q == RUN;
    assign done    = state_q == DONE;
`ifdef CTRL_EVENT_SCHED_LOOP_EN
    assign wrap_pulse = wrap_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_q;
`endif
endmodule

// File: doc/ctrl_event_sched.md
Name: ctrl_event_sched

Overview:
- Time-triggered event scheduler for the PV real-time simulation datapath.
- Holds a small table of (step time, 64-bit value) events and steps through them in order against the global simulation step counter.
- Drives an extended-precision source value (breaker command, irradiance step, fault magnitude) into the solver.
- Generalises single-event switching to a programmable multi-event sequence with a config port and run control.

Parameters:
- DEPTH, 8, number of event table entries (power of two).
- AW, 3, table address width, log2(DEPTH).
- CNT_W, 12, width of step counter and event times.
- DATA_W, 64, value width; equals `EXTENDED_SINGLE.

Ports:
- clk  in  1  system clock.
- sta  in  1  reset. Synchronous, active-high. Also serves as simulation start strobe.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table entry index.
- cfg_time  in  CNT_W  event step time.
- cfg_value  in  DATA_W  event output value.
- cfg_num  in  AW+1  number of valid events (0..DEPTH); sampled on arm.
- arm  in  1  start-sequence pulse.
- step_en  in  1  one-cycle pulse when the counter has advanced to a new value.
- counter  in  CNT_W  global simulation step counter.
- y  out  DATA_W  scheduled output value (registered).
- y_upd  out  1  one-cycle pulse when y changes due to an event.
- evt_idx  out  AW+1  index of the next pending event.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (sta=1 at a clk edge):
  - state=IDLE; y=0, y_upd=0, evt_idx=0, busy=0, done=0, stored num=0.
  - Table contents are not cleared.
- States: IDLE, RUN, DONE.
- Config writes:
  - cfg_we in IDLE or DONE writes time/value at cfg_addr at the clock edge.
  - cfg_we in RUN is ignored; the table is locked.
- arm in any state:
  - num <= cfg_num, evt_idx <= 0, y <= 0, y_upd <= 0.
  - If cfg_num == 0: go to DONE (busy=0, done=1). Otherwise go to RUN (busy=1, done=0).
  - arm in RUN restarts the sequence from index 0.
  - cfg_num > DEPTH is clamped to DEPTH.
- RUN match rule:
  - A match occurs on a cycle with step_en=1 and counter == time[evt_idx] - 1, computed modulo 2^CNT_W (time 0 matches counter 4095).
  - On match, at the next edge: y <= value[evt_idx], y_upd=1 for exactly one cycle, evt_idx <= evt_idx+1.
  - Latency is 1 clk from the matching step_en cycle to y valid.
- Non-match cycles:
  - When step_en=0 or there is no match, y holds and y_upd=0.
  - Counter values held across multiple step_en=0 cycles never re-trigger.
- Table order and timing:
  - Events are consumed strictly in index order; at most one event fires per step_en pulse.
  - Equal or out-of-order times are not skipped. A later entry whose time has already passed waits for counter wrap-around.
- Last event: when the matched event is index num-1, go to DONE after the update. In DONE, y holds the last value, busy=0, done=1.
- IDLE: y holds, no matching.
- Simultaneous events:
  - sta has priority over arm, cfg_we and match.
  - arm has priority over a same-cycle match; the match is discarded.
  - cfg_we together with arm in IDLE/DONE: the write completes, and arm uses the old table contents only for entries read that same cycle. The first compare occurs at the earliest on the next cycle, so the written entry is visible.
- sta asserted mid-RUN: immediate return to IDLE with the reset values above.

Optional Feature:
- Macro: CTRL_EVENT_SCHED_LOOP_EN.
- When defined, after the event at index num-1 fires:
  - evt_idx wraps to 0 and state stays RUN, producing a periodic sequence keyed to counter wrap-around.
  - done never asserts.
  - An added output wrap_pulse pulses 1 cycle at each wrap.
- When undefined: behaviour is as above (DONE holds the last value), and wrap_pulse does not exist.

Test Plan:
- Reset then idle:
  - Stimulus: sta=1 for 2 clk, step counter 0..20 with step_en.
  - Required response: y=0, y_upd never high, busy=0, done=0.
- Three-event sequence:
  - Stimulus: load (10, 0x3FF0000000000000), (20, 0x4000000000000000), (30, 0); cfg_num=3; arm; step counter 0..40.
  - Required response: y changes one clk after the counter=9/19/29 step_en cycles; exactly three y_upd pulses; done=1 after the third; y=0 at end.
- Step hold:
  - Stimulus: counter held at 9 with step_en=0 for 50 clk, then step_en once.
  - Required response: exactly one update, on the step_en cycle +1.
- Wrap-around and zero count:
  - Stimulus: event time 0 with counter stepping 4094 -> 4095.
  - Required response: fires at counter=4095.
  - Stimulus: cfg_num=0, then arm.
  - Required response: done=1 next clk, y=0.
- Locking and restart:
  - Stimulus: cfg_we during RUN.
  - Required response: the table is unchanged (rerun gives the original values).
  - Stimulus: arm mid-RUN at evt_idx=2.
  - Required response: evt_idx=0, y=0.
  - Stimulus: sta mid-RUN.
  - Required response: IDLE, all outputs at reset values.
- Loop mode (CTRL_EVENT_SCHED_LOOP_EN defined):
  - Stimulus: 2 events at times 5 and 100; counter run through two full 4096 periods.
  - Required response: 4 y_upd pulses and 2 wrap_pulse pulses; done stays 0.
